ext_mem_arbiter: RTL and testbench
==================================

# ext_mem_arbiter

Round-robin arbiter and invalidate sequencer for the shared L2 cache in the external memory subsystem. It grants the L2 native front-end to one of N_MASTERS L1 back-end buses at a time, holds that grant until the transaction completes, and returns the response to the granted master only. It also converts asynchronous invalidate requests from the L1 data cache into a single-cycle L2 force-invalidate. That pulse is issued only when no L2 transaction is in flight and the L2 write-through buffer is empty.

## Interface
- N_MASTERS, 2: number of requesters; legal values 1..4.
- ADDR_W, 25: native bus word-address width.
- DATA_W, 32: native bus data width.

- clk  input  1  clock.
- rst  input  1  reset; asynchronous, active-high.
- m_valid  input  N_MASTERS  per-master request valid. Held with all request fields stable until the matching m_ready.
- m_addr  input  N_MASTERS*ADDR_W  per-master address; master i occupies bits [i*ADDR_W +: ADDR_W].
- m_wdata  input  N_MASTERS*DATA_W  per-master write data.
- m_wstrb  input  N_MASTERS*DATA_W/8  per-master byte strobes; 0 means read.
- m_rdata  output  N_MASTERS*DATA_W  s_rdata replicated to every slot; qualified only by m_ready.
- m_ready  output  N_MASTERS  per-master completion; at most one bit set per cycle.
- s_valid, s_addr, s_wdata, s_wstrb  output  1/ADDR_W/DATA_W/DATA_W/8  request to the L2 cache.
- s_rdata  input  DATA_W  L2 read data.
- s_ready  input  1  L2 completion.
- inv_req  input  1  single-cycle invalidate request from the L1 dcache.
- wtb_empty  input  1  L2 write-through buffer empty.
- s_force_inv  output  1  single-cycle L2 invalidate.
- busy  output  1  high in BUSY and INV states, or while an invalidate is pending.

## Operation
- States:
  - IDLE: no grant.
  - BUSY: grant held to one master.
  - INV: invalidate issue cycle.
- Registers:
  - state
  - grant index g, width max(1, clog2(N_MASTERS))
  - round-robin pointer p
  - inv_pend
- inv_pend behaviour:
  - Set on inv_req in any state.
  - Cleared on the cycle s_force_inv=1.
  - Multiple inv_req pulses while pending collapse into one invalidate.
- IDLE transitions, in priority order:
  - If inv_pend and wtb_empty: go to INV.
  - Else if inv_pend: stay in IDLE. No grant is given, so new requests cannot overtake the pending invalidate.
  - Else if any m_valid: g = first i with m_valid[i], searching from p upward modulo N_MASTERS; go to BUSY.
- BUSY datapath:
  - s_valid = m_valid[g].
  - s_addr, s_wdata, s_wstrb are muxed combinationally from slot g.
  - m_ready[g] = s_ready; every other m_ready bit is 0.
- BUSY transitions:
  - On s_ready: p = (g+1) mod N_MASTERS; go to IDLE.
  - If m_valid[g] falls without s_ready (protocol violation): go to IDLE, p unchanged, no m_ready.
- INV: s_force_inv=1 for exactly one cycle, inv_pend cleared, next state IDLE.
- Outputs in IDLE and INV:
  - s_valid=0
  - m_ready=0
  - s_addr/s_wdata/s_wstrb driven from slot p; the value is don't-care.
- N_MASTERS=1: p and g are constant 0; behaviour is otherwise identical.

## Timing
- Reset values:
  - state=IDLE, p=0, g=0, inv_pend=0.
  - s_valid=0, m_ready=0, s_force_inv=0, busy=0.
- Reset mid-transaction: the transaction is dropped immediately with no m_ready; the master must reissue.
- Arbitration latency: one cycle. m_valid sampled high in IDLE at cycle t gives s_valid=1 at t+1.
- Completion: s_ready at cycle t gives m_ready at t (combinational) and state IDLE at t+1. The earliest next grant is s_valid at t+2.
- Back-to-back requests from one master with another master waiting: the waiting master wins the next IDLE cycle.
- inv_req in the same cycle as s_ready: the transaction completes normally. The next IDLE cycle goes to INV if wtb_empty, so s_force_inv rises at t+2.
- inv_req in the same cycle as an IDLE grant decision: the grant wins because inv_pend is not yet set. The invalidate follows that transaction.
- The L2 never sees s_valid and s_force_inv high in the same cycle.

## Test plan
- Reset, then 2 masters idle: all outputs 0 and busy=0. Assert rst for 1 cycle mid-BUSY: s_valid drops in the same cycle and no m_ready is issued.
- Master 0 reads addr 0x100; L2 returns s_ready with rdata 0xDEADBEEF 3 cycles after s_valid. Required response:
  - m_ready[0] pulses in that cycle with m_rdata[31:0]=0xDEADBEEF.
  - m_ready[1] stays 0.
- Both masters assert valid continuously, L2 ready after 1 cycle: grants alternate 0,1,0,1. Over 8 transactions each master gets exactly 4.
- Master 1 write, addr 0x2A, wdata 0x12345678, wstrb 0xF: s_addr, s_wdata and s_wstrb equal those values throughout BUSY; m_ready[1] equals s_ready.
- inv_req during a 5-cycle-latency transaction, wtb_empty=0 for 4 more cycles after completion. Required response:
  - No new grant is given.
  - s_force_inv=1 for exactly one cycle, the cycle after wtb_empty rises.
  - A pending master is then granted.
- Three inv_req pulses while wtb_empty=0: exactly one s_force_inv pulse.

Source files
------------

// File: rtl/ext_mem_arbiter_if.sv
// Native-bus bundle between the L1 back-end masters and the shared L2 front-end.
// The arbiter uses the master modport; the L1/L2 environment uses the slave modport.
interface ext_mem_arbiter_if #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32
);
  logic [N_MASTERS-1:0]            m_valid;
  logic [N_MASTERS*ADDR_W-1:0]     m_addr;
  logic [N_MASTERS*DATA_W-1:0]     m_wdata;
  logic [N_MASTERS*DATA_W/8-1:0]   m_wstrb;
  logic [N_MASTERS*DATA_W-1:0]     m_rdata;
  logic [N_MASTERS-1:0]            m_ready;
  logic                            s_valid;
  logic [ADDR_W-1:0]               s_addr;
  logic [DATA_W-1:0]               s_wdata;
  logic [DATA_W/8-1:0]             s_wstrb;
  logic [DATA_W-1:0]               s_rdata;
  logic                            s_ready;

  modport master (
    input  m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    output m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
  );

  modport slave (
    output m_valid, m_addr, m_wdata, m_wstrb, s_rdata, s_ready,
    input  m_rdata, m_ready, s_valid, s_addr, s_wdata, s_wstrb
  );
endinterface

// File: rtl/ext_mem_arbiter.sv
// Round-robin arbiter of N L1 back-end buses onto the L2 native front-end,
// plus the sequencer that turns L1 invalidate requests into one L2 force-invalidate.
module ext_mem_arbiter #(
  parameter int N_MASTERS = 2,
  parameter int ADDR_W    = 25,
  parameter int DATA_W    = 32
) (
  input  logic                clk,
  input  logic                rst,
  ext_mem_arbiter_if.master   bus,
  input  logic                inv_req,
  input  logic                wtb_empty,
  output logic                s_force_inv,
  output logic                busy
);

  localparam int GW     = (N_MASTERS > 1) ? $clog2(N_MASTERS) : 1;
  localparam int STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    INV  = 2'd2
  } state_t;

  state_t        state, state_nxt;
  logic [GW-1:0] g, g_nxt;
  logic [GW-1:0] p, p_nxt;
  logic          inv_pend, inv_pend_nxt;
  logic [GW-1:0] pick, cand, sel;
  logic          any_valid;

  function automatic logic [GW-1:0] wrap_inc(input logic [GW-1:0] i);
    if (int'(i) >= N_MASTERS - 1) return '0;
    return i + 1'b1;
  endfunction

  // First requester at or above the round-robin pointer, wrapping around.
  always_comb begin
    pick      = p;
    any_valid = 1'b0;
    cand      = p;
    for (int k = 0; k < N_MASTERS; k++) begin
      if (!any_valid && bus.m_valid[cand]) begin
        any_valid = 1'b1;
        pick      = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_nxt    = state;
    g_nxt        = g;
    p_nxt        = p;
    // A request arriving on the issue cycle is kept so it gets its own invalidate.
    inv_pend_nxt = inv_req | (inv_pend & (state != INV));
    case (state)
      IDLE: begin
        if (inv_pend && wtb_empty) begin
          state_nxt = INV;
        end else if (!inv_pend && any_valid) begin
          g_nxt     = pick;
          state_nxt = BUSY;
        end
      end
      BUSY: begin
        if (bus.s_ready) begin
          p_nxt     = wrap_inc(g);
          state_nxt = IDLE;
        end else if (!bus.m_valid[g]) begin
          state_nxt = IDLE;
        end
      end
      INV: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      g        <= '0;
      p        <= '0;
      inv_pend <= 1'b0;
    end else begin
      state    <= state_nxt;
      g        <= g_nxt;
      p        <= p_nxt;
      inv_pend <= inv_pend_nxt;
    end
  end

  // Request fields follow the grant while busy, otherwise the pointer slot.
  assign sel         = (state == BUSY) ? g : p;
  assign bus.s_addr  = bus.m_addr[sel*ADDR_W +: ADDR_W];
  assign bus.s_wdata = bus.m_wdata[sel*DATA_W +: DATA_W];
  assign bus.s_wstrb = bus.m_wstrb[sel*STRB_W +: STRB_W];
  assign bus.m_rdata = {N_MASTERS{bus.s_rdata}};

  always_comb begin
    bus.s_valid = 1'b0;
    bus.m_ready = '0;
    s_force_inv = 1'b0;
    case (state)
      BUSY: begin
        bus.s_valid    = bus.m_valid[g];
        bus.m_ready[g] = bus.s_ready;
      end
      INV: begin
        s_force_inv = 1'b1;
      end
      default: begin
        bus.s_valid = 1'b0;
      end
    endcase
  end

  assign busy = (state != IDLE) | inv_pend;

endmodule

// File: tb/tb_ext_mem_arbiter.sv
// Directed bench for ext_mem_arbiter: a transaction-level model checked every cycle
// plus literal expectations for latency, ordering and invalidate timing.
module tb_ext_mem_arbiter;
  localparam int N  = 2;
  localparam int AW = 25;
  localparam int DW = 32;
  localparam int SW = DW / 8;

  logic clk = 1'b0;
  logic rst;
  logic inv_req;
  logic wtb_empty;
  logic s_force_inv;
  logic busy;

  ext_mem_arbiter_if #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) bus ();

  ext_mem_arbiter #(.N_MASTERS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
    .clk         (clk),
    .rst         (rst),
    .bus         (bus),
    .inv_req     (inv_req),
    .wtb_empty   (wtb_empty),
    .s_force_inv (s_force_inv),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int inv_count = 0;
  int inv_cyc   = -1;
  int grants[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Transaction-level model: who owns the L2, where round-robin resumes,
  // whether an invalidate is owed and whether this is its issue cycle.
  int       owner = -1;
  int       ptr   = 0;
  bit       pend  = 1'b0;
  bit       invc  = 1'b0;
  bit       nxt_pend;
  bit       own_valid;
  logic [N-1:0] exp_rdy;

  always @(negedge clk) begin
    if (s_force_inv) begin
      inv_count++;
      inv_cyc = cyc;
    end
    for (int i = 0; i < N; i++)
      if (((bus.m_ready >> i) & 1) != 0) grants.push_back(i);

    if (rst) begin
      chk("rst_s_valid", 64'(bus.s_valid), 64'(0));
      chk("rst_m_ready", 64'(bus.m_ready), 64'(0));
      chk("rst_force_inv", 64'(s_force_inv), 64'(0));
      chk("rst_busy", 64'(busy), 64'(0));
      owner = -1; ptr = 0; pend = 1'b0; invc = 1'b0;
    end else begin
      own_valid = (owner >= 0) && (((bus.m_valid >> owner) & 1) != 0);
      exp_rdy   = (owner >= 0 && bus.s_ready) ? (N'(1) << owner) : '0;
      chk("m_s_valid", 64'(bus.s_valid), 64'(own_valid));
      chk("m_m_ready", 64'(bus.m_ready), 64'(exp_rdy));
      chk("m_force_inv", 64'(s_force_inv), 64'(invc));
      chk("m_busy", 64'(busy), 64'((owner >= 0) || invc || pend));
      chk("m_rdata", 64'(bus.m_rdata), 64'({N{bus.s_rdata}}));
      chk("m_no_overlap", 64'(bus.s_valid & s_force_inv), 64'(0));
      if (owner >= 0) begin
        chk("m_s_addr", 64'(bus.s_addr), 64'(AW'(bus.m_addr >> (owner * AW))));
        chk("m_s_wdata", 64'(bus.s_wdata), 64'(DW'(bus.m_wdata >> (owner * DW))));
        chk("m_s_wstrb", 64'(bus.s_wstrb), 64'(SW'(bus.m_wstrb >> (owner * SW))));
      end
      nxt_pend = pend;
      if (invc) begin
        invc     = 1'b0;
        nxt_pend = 1'b0;
      end else if (owner >= 0) begin
        if (bus.s_ready) begin
          ptr   = (owner + 1) % N;
          owner = -1;
        end else if (!own_valid) begin
          owner = -1;
        end
      end else if (pend && wtb_empty) begin
        invc = 1'b1;
      end else if (!pend) begin
        for (int k = 0; k < N; k++)
          if (owner < 0 && (((bus.m_valid >> ((ptr + k) % N)) & 1) != 0))
            owner = (ptr + k) % N;
      end
      pend = nxt_pend | inv_req;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sv(input string name);
    int n = 0;
    while (!bus.s_valid && n < 20) begin
      tick();
      n++;
    end
    chk(name, 64'(bus.s_valid), 64'(1));
  endtask

  int exp_ord[8] = '{0, 1, 0, 1, 0, 1, 0, 1};
  int ic0, rise, n0, gsz;

  initial begin
    rst = 1'b1; inv_req = 1'b0; wtb_empty = 1'b1;
    bus.m_valid = '0; bus.m_addr = '0; bus.m_wdata = '0; bus.m_wstrb = '0;
    bus.s_rdata = '0; bus.s_ready = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    repeat (2) tick();
    chk("idle_busy", 64'(busy), 64'(0));
    chk("idle_s_valid", 64'(bus.s_valid), 64'(0));
    chk("idle_m_ready", 64'(bus.m_ready), 64'(0));

    // Master 0 read, L2 answers three cycles after s_valid
    bus.m_addr[0 +: AW] = AW'('h100);
    bus.m_wstrb = '0;
    bus.m_valid = 2'b01;
    tick();
    chk("arb_latency", 64'(bus.s_valid), 64'(1));
    chk("rd_addr", 64'(bus.s_addr), 64'('h100));
    repeat (3) tick();
    bus.s_rdata = 32'hDEADBEEF;
    bus.s_ready = 1'b1;
    #1;
    chk("rd_m_ready", 64'(bus.m_ready), 64'(2'b01));
    chk("rd_m_rdata0", 64'(bus.m_rdata[31:0]), 64'(32'hDEADBEEF));
    tick();
    bus.m_valid = '0; bus.s_ready = 1'b0; bus.s_rdata = '0;
    tick();

    // Master 1 write
    bus.m_addr[AW +: AW]  = AW'('h2A);
    bus.m_wdata[DW +: DW] = 32'h12345678;
    bus.m_wstrb[SW +: SW] = 4'hF;
    bus.m_valid = 2'b10;
    tick();
    wait_sv("wr_grant");
    for (int i = 0; i < 3; i++) begin
      chk("wr_s_addr", 64'(bus.s_addr), 64'('h2A));
      chk("wr_s_wdata", 64'(bus.s_wdata), 64'(32'h12345678));
      chk("wr_s_wstrb", 64'(bus.s_wstrb), 64'(4'hF));
      chk("wr_m_ready_low", 64'(bus.m_ready), 64'(0));
      tick();
    end
    bus.s_ready = 1'b1;
    #1;
    chk("wr_m_ready", 64'(bus.m_ready), 64'(2'b10));
    chk("wr_s_addr_last", 64'(bus.s_addr), 64'('h2A));
    tick();
    bus.m_valid = '0; bus.s_ready = 1'b0; bus.m_wstrb = '0;
    tick();

    // Both masters request continuously; grants must alternate
    grants.delete();
    bus.m_addr = {AW'('h20), AW'('h10)};
    bus.m_valid = 2'b11;
    for (int t = 0; t < 8; t++) begin
      wait_sv("rr_grant");
      tick();
      bus.s_ready = 1'b1;
      tick();
      bus.s_ready = 1'b0;
    end
    bus.m_valid = '0;
    tick();
    chk("rr_count", 64'(grants.size()), 64'(8));
    n0 = 0;
    for (int i = 0; i < 8; i++) begin
      if (i < grants.size()) begin
        chk("rr_order", 64'(grants[i]), 64'(exp_ord[i]));
        if (grants[i] == 0) n0++;
      end
    end
    chk("rr_master0_share", 64'(n0), 64'(4));

    // Invalidate during a 5-cycle transaction, write-through buffer drains late
    ic0 = inv_count;
    wtb_empty = 1'b0;
    bus.m_valid = 2'b01;
    tick();
    wait_sv("inv_txn_grant");
    tick();
    inv_req = 1'b1;
    bus.m_valid = 2'b11;
    tick();
    inv_req = 1'b0;
    repeat (2) tick();
    bus.s_ready = 1'b1;
    #1;
    chk("inv_txn_ready", 64'(bus.m_ready), 64'(2'b01));
    tick();
    bus.s_ready = 1'b0;
    bus.m_valid = 2'b10;
    chk("inv_pending_busy", 64'(busy), 64'(1));
    for (int i = 0; i < 4; i++) begin
      chk("inv_no_grant", 64'(bus.s_valid), 64'(0));
      chk("inv_held", 64'(s_force_inv), 64'(0));
      tick();
    end
    wtb_empty = 1'b1;
    rise = cyc;
    tick();
    chk("inv_issue", 64'(s_force_inv), 64'(1));
    chk("inv_issue_no_valid", 64'(bus.s_valid), 64'(0));
    tick();
    chk("inv_single", 64'(s_force_inv), 64'(0));
    tick();
    chk("inv_then_grant", 64'(bus.s_valid), 64'(1));
    chk("inv_timing", 64'(inv_cyc), 64'(rise + 1));
    bus.s_ready = 1'b1;
    #1;
    chk("inv_pending_master", 64'(bus.m_ready), 64'(2'b10));
    tick();
    bus.s_ready = 1'b0; bus.m_valid = '0;
    tick();
    chk("inv_pulses", 64'(inv_count - ic0), 64'(1));

    // Three invalidate requests collapse into one pulse
    ic0 = inv_count;
    wtb_empty = 1'b0;
    for (int i = 0; i < 3; i++) begin
      inv_req = 1'b1;
      tick();
      inv_req = 1'b0;
      repeat (2) tick();
    end
    chk("coll_busy", 64'(busy), 64'(1));
    chk("coll_held", 64'(inv_count - ic0), 64'(0));
    wtb_empty = 1'b1;
    repeat (4) tick();
    chk("coll_pulses", 64'(inv_count - ic0), 64'(1));
    chk("coll_idle", 64'(busy), 64'(0));

    // Reset in the middle of a transaction
    gsz = grants.size();
    bus.m_valid = 2'b01;
    tick();
    wait_sv("rst_txn_grant");
    tick();
    rst = 1'b1;
    bus.s_ready = 1'b1;
    #1;
    chk("rst_drop_s_valid", 64'(bus.s_valid), 64'(0));
    chk("rst_drop_m_ready", 64'(bus.m_ready), 64'(0));
    tick();
    rst = 1'b0; bus.s_ready = 1'b0; bus.m_valid = '0;
    tick();
    chk("rst_after_busy", 64'(busy), 64'(0));
    chk("rst_no_response", 64'(grants.size()), 64'(gsz));

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, got cycle %0d required completion", cyc);
    $fatal(1, "watchdog");
  end
endmodule
